// File: rtl/cpu_controller_if.sv
// Controller-to-decoder/datapath bundle for the 16-bit RISC core.
// master = controller, slave = top level / datapath side.
interface cpu_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       write;
  logic       w;

  modport master (
    input  s, opcode, op,
    output nsel, vsel, loada, loadb, loadc,
    output loads, asel, bsel, write, w
  );

  modport slave (
    output s, opcode, op,
    input  nsel, vsel, loada, loadb, loadc,
    input  loads, asel, bsel, write, w
  );
endinterface

// File: rtl/cpu_controller.sv
// Moore FSM sequencing the register-file/ALU datapath,
// one instruction at a time; outputs registered from next state.
module cpu_controller (
  input  logic             clk,
  input  logic             reset,
  cpu_controller_if.master bus
);

  typedef enum logic [3:0] {
    WAIT,
    DECODE,
    WRITE_IMM,
    GET_A,
    GET_B,
    ALU_AB,
    ALU_B,
    CMP,
    WRITE_REG
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [4:0] ins;

  assign ins = {bus.opcode, bus.op};

  // Next-state selection; reset overrides everything.
  always_comb begin
    nxt = state;
    case (state)
      WAIT:      nxt = bus.s ? DECODE : WAIT;
      DECODE: begin
        case (ins)
          5'b110_10: nxt = WRITE_IMM;
          5'b110_00: nxt = GET_B;
          5'b101_00: nxt = GET_A;
          5'b101_01: nxt = GET_A;
          5'b101_10: nxt = GET_A;
          5'b101_11: nxt = GET_B;
          default:   nxt = WAIT;
        endcase
      end
      WRITE_IMM: nxt = WAIT;
      GET_A:     nxt = GET_B;
      GET_B: begin
        if (bus.opcode == 3'b110 || bus.op == 2'b11)
          nxt = ALU_B;
        else if (bus.op == 2'b01)
          nxt = CMP;
        else
          nxt = ALU_AB;
      end
      ALU_AB:    nxt = WRITE_REG;
      ALU_B:     nxt = WRITE_REG;
      CMP:       nxt = WAIT;
      WRITE_REG: nxt = WAIT;
      default:   nxt = WAIT;
    endcase
    if (reset) nxt = WAIT;
  end

  // State register plus outputs decoded from the state being entered,
  // so every strobe is a flop and a pure function of the state.
  always_ff @(posedge clk) begin
    state     <= nxt;
    bus.nsel  <= 3'b000;
    bus.vsel  <= 2'b00;
    bus.loada <= 1'b0;
    bus.loadb <= 1'b0;
    bus.loadc <= 1'b0;
    bus.loads <= 1'b0;
    bus.asel  <= 1'b0;
    bus.bsel  <= 1'b0;
    bus.write <= 1'b0;
    bus.w     <= 1'b0;
    case (nxt)
      WAIT:      bus.w <= 1'b1;
      WRITE_IMM: begin
        bus.nsel  <= 3'b001;
        bus.vsel  <= 2'b10;
        bus.write <= 1'b1;
      end
      GET_A: begin
        bus.nsel  <= 3'b001;
        bus.loada <= 1'b1;
      end
      GET_B: begin
        bus.nsel  <= 3'b100;
        bus.loadb <= 1'b1;
      end
      ALU_AB:    bus.loadc <= 1'b1;
      ALU_B: begin
        bus.loadc <= 1'b1;
        bus.asel  <= 1'b1;
      end
      CMP:       bus.loads <= 1'b1;
      WRITE_REG: begin
        bus.nsel  <= 3'b010;
        bus.write <= 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller.
// Outputs packed as {w,nsel,vsel,loada,loadb,loadc,loads,asel,bsel,write}.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic reset;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [12:0] ST_W    = 13'b1_000_00_0000000;
  localparam logic [12:0] ST_DEC  = 13'b0_000_00_0000000;
  localparam logic [12:0] ST_WIMM = 13'b0_001_10_0000001;
  localparam logic [12:0] ST_GA   = 13'b0_001_00_1000000;
  localparam logic [12:0] ST_GB   = 13'b0_100_00_0100000;
  localparam logic [12:0] ST_AAB  = 13'b0_000_00_0010000;
  localparam logic [12:0] ST_AB   = 13'b0_000_00_0010100;
  localparam logic [12:0] ST_CMP  = 13'b0_000_00_0001000;
  localparam logic [12:0] ST_WR   = 13'b0_010_00_0000001;

  int n_vec = 0;
  int n_bad = 0;
  logic [12:0] seq [$];
  logic [12:0] out;

  assign out = {bus.w, bus.nsel, bus.vsel, bus.loada, bus.loadb,
                bus.loadc, bus.loads, bus.asel, bus.bsel, bus.write};

  task automatic chk(input string tag, input logic [12:0] got,
                     input logic [12:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // Start an instruction at this negedge and check each following cycle.
  task automatic run(input string tag, input logic [2:0] opc,
                     input logic [1:0] o, input bit hold);
    bus.opcode = opc;
    bus.op     = o;
    bus.s      = 1'b1;
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      if (!hold) bus.s = 1'b0;
      chk($sformatf("%s[%0d]", tag, i), out, seq[i]);
    end
    bus.s = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bus.s      = 1'b0;
    bus.opcode = 3'b000;
    bus.op     = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    chk("reset", out, ST_W);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), out, ST_W);
    end

    seq = '{ST_DEC, ST_WIMM, ST_W};
    run("movimm", 3'b110, 2'b10, 1'b0);

    seq = '{ST_DEC, ST_GA, ST_GB, ST_AAB, ST_WR, ST_W};
    run("add", 3'b101, 2'b00, 1'b0);
    run("and", 3'b101, 2'b10, 1'b0);

    seq = '{ST_DEC, ST_GA, ST_GB, ST_CMP, ST_W};
    run("cmp", 3'b101, 2'b01, 1'b0);

    seq = '{ST_DEC, ST_GB, ST_AB, ST_WR, ST_W};
    run("mvn", 3'b101, 2'b11, 1'b0);
    run("movreg", 3'b110, 2'b00, 1'b0);

    seq = '{ST_DEC, ST_W};
    run("undef", 3'b111, 2'b00, 1'b0);
    run("undef2", 3'b110, 2'b01, 1'b0);

    seq = '{ST_DEC, ST_WIMM, ST_W, ST_DEC, ST_WIMM, ST_W};
    run("b2b", 3'b110, 2'b10, 1'b1);
    @(negedge clk);
    chk("b2b_end", out, ST_W);

    seq = '{ST_DEC, ST_GA, ST_GB};
    run("rst_add", 3'b101, 2'b00, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid", out, ST_W);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_idle%0d", i), out, ST_W);
    end

    seq = '{ST_DEC, ST_GA, ST_GB, ST_AAB, ST_WR, ST_W};
    run("add_after", 3'b101, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
